// File: rtl/dual_port_memory.sv
// ---------------------------------------------------------------------------
// dual_port_memory
//   Single-clock memory with one read/write port (A, byte-lane write enables)
//   and one read-only port (B). After reset, and on request, a clear sweep
//   writes clear_value to every location. Both ports are locked out while the
//   sweep runs.
//
// Parameters
//   addr_width  : address bits, depth = 2**addr_width words
//   data_width  : word bits (multiple of 8), nb = data_width/8 byte lanes
//   rdw_mode    : 0 = read-first (old data), 1 = write-first (merged new data)
//   clear_value : word written to every location by the clear sweep
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   clear          : request a new clear sweep (honoured only when idle)
//   busy           : high while the clear sweep is running
//   a_en, a_write  : port A request and write qualifier
//   a_be           : port A per-byte write enables
//   a_addr,a_wdata : port A address and write data
//   a_rdata,a_valid: port A read data (1-cycle latency) and its strobe
//   b_en, b_addr   : port B read request and address
//   b_rdata,b_valid: port B read data (1-cycle latency) and its strobe
// ---------------------------------------------------------------------------
module dual_port_memory #(
  parameter int                    addr_width  = 8,
  parameter int                    data_width  = 8,
  parameter int                    rdw_mode    = 0,
  parameter logic [data_width-1:0] clear_value = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    a_en,
  input  logic                    a_write,
  input  logic [data_width/8-1:0] a_be,
  input  logic [addr_width-1:0]   a_addr,
  input  logic [data_width-1:0]   a_wdata,
  output logic [data_width-1:0]   a_rdata,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic [addr_width-1:0]   b_addr,
  output logic [data_width-1:0]   b_rdata,
  output logic                    b_valid
);

  localparam int depth = 2 ** addr_width;
  localparam int nb    = data_width / 8;
  localparam logic [addr_width-1:0] CNT_STEP = {{(addr_width-1){1'b0}}, 1'b1};

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                r_state;
  logic [addr_width-1:0] r_cnt;
  logic                  r_busy;
  logic [data_width-1:0] r_aRdata;
  logic [data_width-1:0] r_bRdata;
  logic                  r_aValid;
  logic                  r_bValid;
  logic [data_width-1:0] r_mem [depth];

  logic [data_width-1:0] w_aOld;
  logic [data_width-1:0] w_bOld;
  logic [data_width-1:0] w_aMerged;
  logic [data_width-1:0] w_aRead;
  logic [data_width-1:0] w_bRead;
  logic                  w_collide;
  logic                  w_userWrite;

  assign w_aOld = r_mem[a_addr];
  assign w_bOld = r_mem[b_addr];

  // Build the word port A leaves behind: enabled byte lanes take the new
  // data, the rest keep the stored value. With no write it is the old word.
  always_comb begin
    w_aMerged = w_aOld;
    for (int i = 0; i < nb; i++) begin
      if (a_write && a_be[i]) begin
        w_aMerged[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
  end

  // Read-during-write handling. In write-first mode both ports see the
  // merged word when they address the location port A is touching; when A
  // only reads, the merged word equals the stored word, so no extra write
  // qualification is needed on the collision term.
  assign w_collide   = a_en && (a_addr == b_addr);
  assign w_aRead     = (rdw_mode == 1) ? w_aMerged : w_aOld;
  assign w_bRead     = ((rdw_mode == 1) && w_collide) ? w_aMerged : w_bOld;
  assign w_userWrite = a_en && a_write && (|a_be);

  // Control FSM with registered outputs. The sweep counter runs 0..depth-1
  // in CLEAR; wrapping past the last address returns to IDLE. User requests
  // are only looked at in IDLE, and a clear request seen in IDLE still lets
  // the request of that same cycle complete before the sweep starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_aRdata <= '0;
      r_bRdata <= '0;
      r_aValid <= 1'b0;
      r_bValid <= 1'b0;
    end else begin
      r_aValid <= 1'b0;
      r_bValid <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + CNT_STEP;
          if (&r_cnt) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (a_en) begin
            r_aRdata <= w_aRead;
            r_aValid <= 1'b1;
          end
          if (b_en) begin
            r_bRdata <= w_bRead;
            r_bValid <= 1'b1;
          end
          if (clear) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array, deliberately without reset so it maps onto RAM. The sweep
  // owns the write port during CLEAR; a reset cycle writes nothing so an
  // in-flight request is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= clear_value;
      end else if (w_userWrite) begin
        r_mem[a_addr] <= w_aMerged;
      end
    end
  end

  assign busy    = r_busy;
  assign a_rdata = r_aRdata;
  assign a_valid = r_aValid;
  assign b_rdata = r_bRdata;
  assign b_valid = r_bValid;

endmodule

// File: tb/tb_dual_port_memory.sv
// ---------------------------------------------------------------------------
// tb_dual_port_memory
//   Bench for dual_port_memory. Two instances share one clock:
//     m0 : defaults (256 x 8, read-first, clear value 0)
//     m1 : 16 x 32, write-first, clear value 0xDEADBEEF
//   Each instance has a behavioural model (word array plus a count of sweep
//   cycles left) that predicts every output; the outputs are compared with
//   it on each falling edge. Directed sequences with literal expectations
//   are followed by a randomized phase with frequent address collisions,
//   occasional clear requests and occasional resets.
// ---------------------------------------------------------------------------
module tb_dual_port_memory;

  localparam int          DEPTH0 = 256;
  localparam int          DEPTH1 = 16;
  localparam logic [31:0] CLEAR1 = 32'hDEADBEEF;

  logic clk = 1'b0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic       m0Rst, m0Clear, m0Busy, m0AEn, m0AWrite, m0AValid, m0BEn, m0BValid;
  logic [0:0] m0ABe;
  logic [7:0] m0AAddr, m0AWdata, m0ARdata, m0BAddr, m0BRdata;

  logic        m1Rst, m1Clear, m1Busy, m1AEn, m1AWrite, m1AValid, m1BEn, m1BValid;
  logic [3:0]  m1ABe, m1AAddr, m1BAddr;
  logic [31:0] m1AWdata, m1ARdata, m1BRdata;

  dual_port_memory m0 (
    .clk(clk), .rst(m0Rst), .clear(m0Clear), .busy(m0Busy),
    .a_en(m0AEn), .a_write(m0AWrite), .a_be(m0ABe), .a_addr(m0AAddr),
    .a_wdata(m0AWdata), .a_rdata(m0ARdata), .a_valid(m0AValid),
    .b_en(m0BEn), .b_addr(m0BAddr), .b_rdata(m0BRdata), .b_valid(m0BValid)
  );

  dual_port_memory #(
    .addr_width(4), .data_width(32), .rdw_mode(1), .clear_value(CLEAR1)
  ) m1 (
    .clk(clk), .rst(m1Rst), .clear(m1Clear), .busy(m1Busy),
    .a_en(m1AEn), .a_write(m1AWrite), .a_be(m1ABe), .a_addr(m1AAddr),
    .a_wdata(m1AWdata), .a_rdata(m1ARdata), .a_valid(m1AValid),
    .b_en(m1BEn), .b_addr(m1BAddr), .b_rdata(m1BRdata), .b_valid(m1BValid)
  );

  // Model state: memory image, sweep cycles still to run, predicted outputs.
  logic [7:0]  mdl0Mem [DEPTH0];
  int          mdl0Left = 0;
  logic [7:0]  mdl0ARdata, mdl0BRdata;
  logic        mdl0AValid, mdl0BValid;
  bit          mdl0Live = 1'b0;

  logic [31:0] mdl1Mem [DEPTH1];
  int          mdl1Left = 0;
  logic [31:0] mdl1ARdata, mdl1BRdata;
  logic        mdl1AValid, mdl1BValid;
  bit          mdl1Live = 1'b0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] res;
    res = oldW;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newW[8*i +: 8];
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model for m0 (read-first, clear value 0). Port B is evaluated against
  // the memory before port A's write lands.
  always @(posedge clk) begin : model0
    logic [7:0] oldA, newA, bWord;
    if (m0Rst) begin
      mdl0Left   = DEPTH0;
      mdl0ARdata = '0;
      mdl0BRdata = '0;
      mdl0AValid = 1'b0;
      mdl0BValid = 1'b0;
      mdl0Live   = 1'b1;
    end else if (mdl0Left > 0) begin
      mdl0Mem[DEPTH0 - mdl0Left] = 8'h00;
      mdl0Left--;
      mdl0AValid = 1'b0;
      mdl0BValid = 1'b0;
    end else begin
      oldA  = mdl0Mem[m0AAddr];
      newA  = m0AWrite ? mergeBytes({24'h0, oldA}, {24'h0, m0AWdata}, {3'b000, m0ABe}) : oldA;
      bWord = mdl0Mem[m0BAddr];
      mdl0AValid = m0AEn;
      mdl0BValid = m0BEn;
      if (m0AEn) begin
        mdl0ARdata       = oldA;
        mdl0Mem[m0AAddr] = newA;
      end
      if (m0BEn) mdl0BRdata = bWord;
      if (m0Clear) mdl0Left = DEPTH0;
    end
  end

  // Model for m1 (write-first, clear value 0xDEADBEEF): a colliding port B
  // read sees the word port A leaves behind.
  always @(posedge clk) begin : model1
    logic [31:0] oldA, newA, bWord;
    if (m1Rst) begin
      mdl1Left   = DEPTH1;
      mdl1ARdata = '0;
      mdl1BRdata = '0;
      mdl1AValid = 1'b0;
      mdl1BValid = 1'b0;
      mdl1Live   = 1'b1;
    end else if (mdl1Left > 0) begin
      mdl1Mem[DEPTH1 - mdl1Left] = CLEAR1;
      mdl1Left--;
      mdl1AValid = 1'b0;
      mdl1BValid = 1'b0;
    end else begin
      oldA  = mdl1Mem[m1AAddr];
      newA  = m1AWrite ? mergeBytes(oldA, m1AWdata, m1ABe) : oldA;
      bWord = (m1AEn && (m1AAddr == m1BAddr)) ? newA : mdl1Mem[m1BAddr];
      mdl1AValid = m1AEn;
      mdl1BValid = m1BEn;
      if (m1AEn) begin
        mdl1ARdata       = newA;
        mdl1Mem[m1AAddr] = newA;
      end
      if (m1BEn) mdl1BRdata = bWord;
      if (m1Clear) mdl1Left = DEPTH1;
    end
  end

  // Per-cycle comparison of every output against the models, on the
  // falling edge so registered outputs have settled.
  always @(negedge clk) begin
    if (mdl0Live) begin
      checkOutput("m0 busy",    32'(m0Busy),    32'(mdl0Left > 0));
      checkOutput("m0 a_valid", 32'(m0AValid),  32'(mdl0AValid));
      checkOutput("m0 a_rdata", 32'(m0ARdata),  32'(mdl0ARdata));
      checkOutput("m0 b_valid", 32'(m0BValid),  32'(mdl0BValid));
      checkOutput("m0 b_rdata", 32'(m0BRdata),  32'(mdl0BRdata));
    end
    if (mdl1Live) begin
      checkOutput("m1 busy",    32'(m1Busy),    32'(mdl1Left > 0));
      checkOutput("m1 a_valid", 32'(m1AValid),  32'(mdl1AValid));
      checkOutput("m1 a_rdata", m1ARdata,       mdl1ARdata);
      checkOutput("m1 b_valid", 32'(m1BValid),  32'(mdl1BValid));
      checkOutput("m1 b_rdata", m1BRdata,       mdl1BRdata);
    end
  end

  // Apply one m0 request for one clock, returning at the next falling edge.
  task automatic m0Drive(input logic aEn, input logic aWrite, input logic [7:0] aAddr,
                         input logic [7:0] aWdata, input logic bEn, input logic [7:0] bAddr);
    m0AEn    = aEn;
    m0AWrite = aWrite;
    m0ABe    = 1'b1;
    m0AAddr  = aAddr;
    m0AWdata = aWdata;
    m0BEn    = bEn;
    m0BAddr  = bAddr;
    @(negedge clk);
  endtask

  task automatic m1Drive(input logic aEn, input logic aWrite, input logic [3:0] be,
                         input logic [3:0] aAddr, input logic [31:0] aWdata,
                         input logic bEn, input logic [3:0] bAddr);
    m1AEn    = aEn;
    m1AWrite = aWrite;
    m1ABe    = be;
    m1AAddr  = aAddr;
    m1AWdata = aWdata;
    m1BEn    = bEn;
    m1BAddr  = bAddr;
    @(negedge clk);
  endtask

  // Count falling edges with m0 busy high, starting from a count already
  // observed; bounded so a stuck busy still ends the wait.
  task automatic waitSweep0(input int already, output int total);
    total = already;
    while (m0Busy && total < 400) begin
      @(negedge clk);
      if (m0Busy) total++;
    end
  endtask

  // Randomized traffic on both instances; narrow address ranges make port
  // collisions common.
  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      m0Rst    = ($urandom_range(0, 699) == 0);
      m0Clear  = ($urandom_range(0, 299) == 0);
      m0AEn    = ($urandom_range(0, 3) != 0);
      m0AWrite = 1'($urandom_range(0, 1));
      m0ABe    = 1'($urandom_range(0, 1));
      m0AAddr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      m0AWdata = 8'($urandom);
      m0BEn    = ($urandom_range(0, 3) != 0);
      m0BAddr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      m1Rst    = ($urandom_range(0, 699) == 0);
      m1Clear  = ($urandom_range(0, 199) == 0);
      m1AEn    = ($urandom_range(0, 3) != 0);
      m1AWrite = 1'($urandom_range(0, 1));
      m1ABe    = 4'($urandom);
      m1AAddr  = 4'($urandom_range(0, 5));
      m1AWdata = $urandom;
      m1BEn    = ($urandom_range(0, 3) != 0);
      m1BAddr  = 4'($urandom_range(0, 5));
      @(negedge clk);
    end
  endtask

  // Safety net in case the main sequence stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;
    m0Rst = 1'b1; m0Clear = 1'b0; m0AEn = 1'b0; m0AWrite = 1'b0; m0ABe = 1'b0;
    m0AAddr = '0; m0AWdata = '0; m0BEn = 1'b0; m0BAddr = '0;
    m1Rst = 1'b1; m1Clear = 1'b0; m1AEn = 1'b0; m1AWrite = 1'b0; m1ABe = '0;
    m1AAddr = '0; m1AWdata = '0; m1BEn = 1'b0; m1BAddr = '0;
    @(negedge clk);
    m0Rst = 1'b0;
    m1Rst = 1'b0;

    $display("[TB] reset and power-up sweep");
    checkOutput("m0 reset busy",    32'(m0Busy),   32'd1);
    checkOutput("m0 reset a_rdata", 32'(m0ARdata), 32'd0);
    checkOutput("m0 reset a_valid", 32'(m0AValid), 32'd0);
    checkOutput("m0 reset b_rdata", 32'(m0BRdata), 32'd0);
    waitSweep0(1, cnt);
    checkOutput("m0 sweep length after reset", cnt, 32'd256);
    checkOutput("m1 idle after its sweep", 32'(m1Busy), 32'd0);

    m0Drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
    checkOutput("m0 read 0x00", 32'(m0ARdata), 32'd0);
    checkOutput("m0 a_valid",   32'(m0AValid), 32'd1);
    checkOutput("m0 read b 0xFF", 32'(m0BRdata), 32'd0);
    m0Drive(1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h00);
    checkOutput("m0 read 0x7F", 32'(m0ARdata), 32'd0);
    m0Drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
    checkOutput("m0 read 0xFF", 32'(m0ARdata), 32'd0);
    checkOutput("m0 b_valid idle", 32'(m0BValid), 32'd0);

    $display("[TB] read-first collision");
    m0Drive(1'b1, 1'b1, 8'h05, 8'h12, 1'b0, 8'h00);
    m0Drive(1'b1, 1'b1, 8'h05, 8'h34, 1'b1, 8'h05);
    checkOutput("m0 rdw0 a_rdata", 32'(m0ARdata), 32'h12);
    checkOutput("m0 rdw0 b_rdata", 32'(m0BRdata), 32'h12);
    m0Drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h05);
    checkOutput("m0 reread a", 32'(m0ARdata), 32'h34);
    checkOutput("m0 reread b", 32'(m0BRdata), 32'h34);
    m0Drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("m0 a_valid one cycle", 32'(m0AValid), 32'd0);
    checkOutput("m0 a_rdata holds",     32'(m0ARdata), 32'h34);

    $display("[TB] fill, clear sweep with blocked requests");
    for (int i = 0; i < DEPTH0; i++) begin
      m0Drive(1'b1, 1'b1, 8'(i), 8'($urandom_range(1, 255)), 1'b0, 8'h00);
    end
    m0Clear = 1'b1;
    m0Drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    m0Clear = 1'b0;
    checkOutput("m0 busy after clear", 32'(m0Busy), 32'd1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      m0Drive(1'b1, 1'b1, 8'($urandom), 8'hA5, 1'b1, 8'($urandom));
      checkOutput("m0 no a_valid in sweep", 32'(m0AValid), 32'd0);
      if (m0Busy) cnt++;
    end
    m0AEn = 1'b0;
    m0BEn = 1'b0;
    waitSweep0(cnt, cnt);
    checkOutput("m0 clear sweep length", cnt, 32'd256);
    for (int i = 0; i < DEPTH0; i++) begin
      m0Drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 8'(DEPTH0 - 1 - i));
      checkOutput("m0 cleared word", 32'(m0ARdata), 32'd0);
    end

    $display("[TB] reset mid-sweep, clear mid-sweep");
    m0Clear = 1'b1;
    m0Drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    m0Clear = 1'b0;
    repeat (99) @(negedge clk);
    m0Rst = 1'b1;
    @(negedge clk);
    m0Rst = 1'b0;
    checkOutput("m0 busy after mid-sweep reset", 32'(m0Busy), 32'd1);
    cnt = 1;
    while (m0Busy && cnt < 400) begin
      m0Clear = (cnt == 50);
      @(negedge clk);
      if (m0Busy) cnt++;
    end
    m0Clear = 1'b0;
    checkOutput("m0 restarted sweep length", cnt, 32'd256);

    $display("[TB] 32-bit write-first instance");
    m1Drive(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, 1'b0, 4'h0);
    checkOutput("m1 cleared word", m1ARdata, CLEAR1);
    m1Drive(1'b1, 1'b1, 4'hF, 4'h2, 32'hAABBCCDD, 1'b0, 4'h0);
    checkOutput("m1 full write returns new", m1ARdata, 32'hAABBCCDD);
    m1Drive(1'b1, 1'b1, 4'h5, 4'h2, 32'h11223344, 1'b0, 4'h0);
    checkOutput("m1 lane write returns merged", m1ARdata, 32'hAA22CC44);
    m1Drive(1'b1, 1'b0, 4'h0, 4'h2, 32'h0, 1'b0, 4'h0);
    checkOutput("m1 lane merge readback", m1ARdata, 32'hAA22CC44);
    checkOutput("m1 a_valid", 32'(m1AValid), 32'd1);
    m1Drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    checkOutput("m1 a_valid one cycle", 32'(m1AValid), 32'd0);
    m1Drive(1'b1, 1'b1, 4'hF, 4'h5, 32'h12, 1'b0, 4'h0);
    m1Drive(1'b1, 1'b1, 4'hF, 4'h5, 32'h34, 1'b1, 4'h5);
    checkOutput("m1 rdw1 a_rdata", m1ARdata, 32'h34);
    checkOutput("m1 rdw1 b_rdata", m1BRdata, 32'h34);
    m1Drive(1'b1, 1'b1, 4'h0, 4'h5, 32'hFFFFFFFF, 1'b0, 4'h0);
    checkOutput("m1 zero-be is read", m1ARdata, 32'h34);
    m1Drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5);
    checkOutput("m1 zero-be no write", m1BRdata, 32'h34);
    m1Clear = 1'b1;
    m1Drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    m1Clear = 1'b0;
    cnt = m1Busy ? 1 : 0;
    while (m1Busy && cnt < 100) begin
      @(negedge clk);
      if (m1Busy) cnt++;
    end
    checkOutput("m1 sweep length", cnt, 32'd16);
    m1Drive(1'b1, 1'b0, 4'h0, 4'h2, 32'h0, 1'b0, 4'h0);
    checkOutput("m1 re-cleared word", m1ARdata, CLEAR1);

    $display("[TB] randomized traffic");
    applyStimulus(3000);
    m0Rst = 1'b0; m0Clear = 1'b0; m0AEn = 1'b0; m0BEn = 1'b0;
    m1Rst = 1'b0; m1Clear = 1'b0; m1AEn = 1'b0; m1BEn = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL have parameter addr_width, default 8, address bits; depth = 2**addr_width words.
REQ-002 SHALL have parameter data_width, default 8, word bits; must be a multiple of 8; nb = data_width/8 byte lanes.
REQ-003 SHALL have parameter rdw_mode, default 0; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have parameter clear_value, default 0, data_width bits, word written by the clear sweep.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port clear  in  1  request to re-run the clear sweep.
REQ-008 SHALL have port busy  out  1  high while the clear sweep is running.
REQ-009 SHALL have ports a_en  in  1  and a_write  in  1; these are the port A request and write qualifier.
REQ-010 SHALL have port a_be  in  nb  port A per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have ports a_addr  in  addr_width  and a_wdata  in  data_width.
REQ-012 SHALL have ports a_rdata  out  data_width  and a_valid  out  1.
REQ-013 SHALL have ports b_en  in  1 and b_addr  in  addr_width; port B is read-only.
REQ-014 SHALL have ports b_rdata  out  data_width  and b_valid  out  1.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-016 In CLEAR, SHALL write clear_value to location cnt each cycle, with cnt running 0 to depth-1, and hold busy=1.
REQ-017 After writing cnt=depth-1, SHALL enter IDLE on the next edge; a sweep is exactly depth cycles long and busy falls with it.
REQ-018 In IDLE with clear=1, SHALL enter CLEAR next cycle with cnt=0; clear while in CLEAR is ignored and does not restart the sweep.
REQ-019 In CLEAR, SHALL ignore a_en and b_en entirely: no user writes, valid outputs 0, rdata outputs hold.
REQ-020 In IDLE with a_en=1, SHALL register a_rdata from a_addr and assert a_valid for exactly one cycle on the following edge; read latency is 1 cycle.
REQ-021 In IDLE with a_en=1 and a_write=1, SHALL update only the byte lanes whose a_be bit is 1; lanes with a_be=0 keep their old value.
REQ-022 a_write=1 with a_be all zero SHALL perform a read only.
REQ-023 On a port A write with rdw_mode=0, a_rdata SHALL return the pre-write word; with rdw_mode=1 it SHALL return the merged post-write word.
REQ-024 In IDLE with b_en=1, SHALL register b_rdata from b_addr and assert b_valid for one cycle, with latency 1.
REQ-025 On a collision (b_addr == a_addr, port A writing, both enabled), b_rdata SHALL follow rdw_mode identically to a_rdata.
REQ-026 When a port is not enabled, its rdata SHALL hold its last value and its valid SHALL be 0.
REQ-027 Back-to-back requests on both ports SHALL be accepted every cycle with no stalls while in IDLE.
REQ-028 Addresses SHALL be used modulo depth; no out-of-range condition exists.

Reset
REQ-029 When rst=1 at a clock edge, SHALL set state=CLEAR, cnt=0, busy=1, a_rdata=0, b_rdata=0, a_valid=0, b_valid=0.
REQ-030 Memory contents SHALL NOT be reset directly; they are initialised only by the sweep that follows reset.
REQ-031 rst asserted mid-sweep or mid-access SHALL restart the sweep from cnt=0 and discard the in-flight request.

Verification
REQ-032 Defaults; pulse rst for 1 cycle -> busy=1 for exactly 256 cycles, then 0; reads of addresses 0x00, 0x7F and 0xFF -> 0x00.
REQ-033 data_width=32; write 0xAABBCCDD with a_be=4'b1111, then write 0x11223344 with a_be=4'b0101 to the same address, then read -> 0xAA22CC44 with a_valid one cycle after a_en.
REQ-034 rdw_mode=0; address 5 holds 0x12; port A writes 0x34 to address 5 while port B reads address 5 -> b_rdata=0x12 and a_rdata=0x12; next read -> 0x34. Same stimulus with rdw_mode=1 -> both ports return 0x34.
REQ-035 Fill memory, pulse clear in IDLE -> busy rises next cycle; a_en pulses during the sweep produce no a_valid and no writes; after depth cycles all locations read clear_value.
REQ-036 Assert rst at sweep cycle 100 -> busy stays high, sweep restarts at cnt=0 and lasts 256 more cycles; a clear pulse mid-sweep does not extend busy.
